// File: rtl/pipe_calc_driver_if.sv
// Operand/result bus between pipe_calc_driver and its environment.
//   in_valid/in_ready + in_a..in_e : operand set stream into the driver
//   pa..pe                         : registered operand bus to the compute pipeline
//   ps                             : pipeline result S
//   out_valid/out_ready + out_data : result stream out of the driver FIFO
//   err/err_cnt                    : sticky mismatch flag and saturating count
// slave = driver side, master = environment side.
interface pipe_calc_driver_if #(parameter int W = 5);
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b, in_c, in_d, in_e;
  logic [W-1:0] pa, pb, pc, pd, pe;
  logic [W-1:0] ps;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;
  logic         err;
  logic [7:0]   err_cnt;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, in_e, ps, out_ready,
    output in_ready, pa, pb, pc, pd, pe, out_valid, out_data, err, err_cnt
  );
  modport master (
    output in_valid, in_a, in_b, in_c, in_d, in_e, ps, out_ready,
    input  in_ready, pa, pb, pc, pd, pe, out_valid, out_data, err, err_cnt
  );
endinterface

// File: rtl/pipe_calc_driver.sv
// Initiator/collector for the 3-stage ((A+B)-(C+D))&E compute pipeline.
// Accepts operand sets, drives them onto the pipeline operand bus, tracks each
// issue through a valid shift register, captures the pipeline result into a
// result FIFO and checks it against an internal model.
// Ports: clk (all state on falling edge), reset (async, active-high),
//        bus (pipe_calc_driver_if.slave, see interface header).
module pipe_calc_driver #(
  parameter int W     = 5,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  pipe_calc_driver_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + LAT + 2);

  typedef struct packed {
    logic [W-1:0] a, b, c, d, e;
  } opset_t;

  opset_t                  in_set, op_q;
  logic [LAT:0]            vld_pipe;
  logic [LAT:0][W-1:0]     exp_pipe;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           occ, inflight;
  logic [W-1:0]            sum_ab, sum_cd, exp_in;
  logic                    issue, cap, pop, err_q;
  logic [7:0]              err_cnt_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign in_set = {bus.in_a, bus.in_b, bus.in_c, bus.in_d, bus.in_e};

  // Model result for the set being offered; W-bit sums wrap naturally.
  assign sum_ab = bus.in_a + bus.in_b;
  assign sum_cd = bus.in_c + bus.in_d;
  assign exp_in = (sum_ab - sum_cd) & bus.in_e;

  always_comb begin
    inflight = '0;
    for (int j = 0; j <= LAT; j++) inflight = inflight + CW'(vld_pipe[j]);
  end

  // Credit: every accepted set holds one slot from issue until it is popped,
  // whether it is still in the pipeline or already buffered.
  assign bus.in_ready  = (occ + inflight) < CW'(DEPTH);
  assign issue         = bus.in_valid && bus.in_ready;
  assign cap           = vld_pipe[LAT];
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.pa        = op_q.a;
  assign bus.pb        = op_q.b;
  assign bus.pc        = op_q.c;
  assign bus.pd        = op_q.d;
  assign bus.pe        = op_q.e;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      vld_pipe  <= '0;
      exp_pipe  <= '0;
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (issue) op_q <= in_set;
      vld_pipe <= {vld_pipe[LAT-1:0], issue};
      exp_pipe <= {exp_pipe[LAT-1:0], exp_in};
      if (cap) begin
        mem[wr_ptr] <= bus.ps;
        wr_ptr      <= ptr_inc(wr_ptr);
        if (bus.ps != exp_pipe[LAT]) begin
          err_q <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({cap, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: ;
      endcase
      // Credit rule makes a capture into a full FIFO without a pop impossible.
      assert (!(cap && occ == CW'(DEPTH) && !pop));
    end
  end
endmodule

// File: tb/tb_pipe_calc_driver.sv
module tb_pipe_calc_driver;
  localparam int W = 5, LAT = 3, DEPTH = 4;

  logic clk   = 1'b1;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_calc_driver_if #(.W(W)) bus();
  pipe_calc_driver #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [W-1:0] calc(input logic [W-1:0] a, b, c, d, e);
    int r;
    r = (int'(a) + int'(b)) - (int'(c) + int'(d));
    return W'(r) & e;
  endfunction

  // Environment: the compute pipeline, LAT falling edges from bus to S.
  // corrupt flips bit 0 of the stage-1 result for one edge.
  logic [W-1:0] s1, s2, s3;
  bit corrupt, pend_bad;
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0; s2 <= '0; s3 <= '0;
    end else begin
      s1 <= calc(bus.pa, bus.pb, bus.pc, bus.pd, bus.pe) ^ W'(corrupt);
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign bus.ps = s3;

  // Reference: every accepted set is outstanding until popped; its result is
  // visible LAT+2 edges after the issue edge.
  typedef struct {
    logic [W-1:0] val;
    int           at;
  } item_t;
  item_t q[$];
  int    bad_at[$];
  int    done, checks, errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int err_exp();
    int n = 0;
    foreach (bad_at[i]) if (bad_at[i] + LAT + 2 <= done) n++;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic step(input bit iv, input logic [W-1:0] a, b, c, d, e,
                      input bit ordy, input bit bad, output bit fired);
    bit rdy, ov;
    item_t it;
    rdy = q.size() < DEPTH;
    ov  = q.size() != 0 && q[0].at + LAT + 2 <= done;
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, ov);
    if (ov) chk("out_data", bus.out_data, q[0].val);
    chk("err_cnt", bus.err_cnt, err_exp());
    chk("err", bus.err, err_exp() != 0);
    bus.in_valid = iv;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d; bus.in_e = e;
    bus.out_ready = ordy;
    fired = iv && rdy;
    if (ordy && ov) void'(q.pop_front());
    if (fired) begin
      it.val = calc(a, b, c, d, e) ^ W'(bad);
      it.at  = done;
      q.push_back(it);
      if (bad) bad_at.push_back(done);
    end
    corrupt  = pend_bad;
    pend_bad = fired && bad;
    @(negedge clk);
    done++;
    @(posedge clk);
  endtask

  task automatic rstep(input bit iv, input bit ordy, output bit fired);
    step(iv, W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
         ordy, 1'b0, fired);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit f;
    for (int i = 0; i < n; i++) rstep(1'b0, ordy, f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_pa", bus.pa, 0);
    @(posedge clk);
    @(posedge clk);
    q.delete();
    bad_at.delete();
    done = 0;
    corrupt = 1'b0;
    pend_bad = 1'b0;
    reset = 1'b0;
  endtask

  logic [W-1:0] sets[6][5];

  initial begin
    bit f;
    int k;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_d = '0; bus.in_e = '0;
    checks = 0; errors = 0;
    do_reset();

    // Basic issue: result 4 after LAT+2 edges.
    step(1'b1, 5'd3, 5'd4, 5'd1, 5'd2, 5'd31, 1'b0, 1'b0, f);
    idle(4, 1'b0);
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_data", bus.out_data, 4);
    idle(2, 1'b1);

    // Add wrap then subtract underflow.
    step(1'b1, 5'd31, 5'd1, 5'd0, 5'd0, 5'd31, 1'b0, 1'b0, f);
    step(1'b1, 5'd0, 5'd0, 5'd1, 5'd0, 5'd31, 1'b0, 1'b0, f);
    idle(5, 1'b0);
    chk("t2_add_wrap", bus.out_data, 0);
    idle(1, 1'b1);
    chk("t2_sub_wrap", bus.out_data, 31);
    idle(3, 1'b1);

    // Credit limit with a stalled consumer.
    foreach (sets[i, j]) sets[i][j] = W'($urandom);
    k = 0;
    for (int t = 0; t < 10; t++) begin
      step(1'b1, sets[k][0], sets[k][1], sets[k][2], sets[k][3], sets[k][4], 1'b0, 1'b0, f);
      if (f) k++;
    end
    chk("t3_accepted", k, 4);
    chk("t3_stalled", bus.in_ready, 0);
    for (int t = 0; t < 40 && (k < 6 || q.size() != 0); t++) begin
      step(k < 6, sets[k < 6 ? k : 0][0], sets[k < 6 ? k : 0][1], sets[k < 6 ? k : 0][2],
           sets[k < 6 ? k : 0][3], sets[k < 6 ? k : 0][4], 1'b1, 1'b0, f);
      if (f) k++;
    end
    chk("t3_all_issued", k, 6);
    chk("t3_drained", bus.out_valid, 0);

    // Streaming with an always-ready consumer.
    k = 0;
    for (int t = 0; t < 80 && k < 16; t++) begin
      rstep(1'b1, 1'b1, f);
      if (f) k++;
    end
    chk("t4_streamed", k, 16);
    idle(8, 1'b1);
    chk("t4_no_err", bus.err, 0);

    // One corrupted capture.
    step(1'b1, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 5'd31, 1'b1, 1'b1, f);
    idle(8, 1'b1);
    chk("t5_err", bus.err, 1);
    chk("t5_err_cnt", bus.err_cnt, 1);
    for (int t = 0; t < 20; t++) rstep($urandom_range(0, 1) == 1, 1'b1, f);
    chk("t5_sticky", bus.err, 1);

    // Reset with 2 in flight and 1 buffered.
    idle(8, 1'b1);
    rstep(1'b1, 1'b0, f);
    rstep(1'b1, 1'b0, f);
    rstep(1'b1, 1'b0, f);
    idle(2, 1'b0);
    chk("t6_buffered", bus.out_valid, 1);
    do_reset();
    idle(10, 1'b1);

    // Random traffic.
    for (int t = 0; t < 400; t++)
      rstep($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, f);
    idle(10, 1'b1);
    chk("final_empty", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
